// File: rtl/debug_pkg.sv
// Shared types and sizing for the debug dump path: sender FSM states, dump phases
// and the byte geometry of a collector word.
package debug_pkg;

    localparam int DEFAULT_LEN    = 32;
    localparam int BYTES_PER_WORD = DEFAULT_LEN / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_LOAD,
        ST_TX,
        ST_WAIT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        PH_PC,
        PH_REG,
        PH_MEM
    } phase_e;

    // Counter width that never collapses to zero bits for single-entry ranges.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_sender.sv
// Serialises the PC, the register file and a data-memory window into bytes for the
// UART, LSB first, while pacing the upstream collector with advance strobes.
module debug_sender
    import debug_pkg::*;
#(
    parameter int LEN      = DEFAULT_LEN,
    parameter int CANT_REG = 16,
    parameter int CANT_MEM = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [LEN-1:0] i_pc,
    input  logic [LEN-1:0] i_data,
    input  logic           i_tx_done,
    output logic           o_enable_next,
    output logic           o_send_regs,
    output logic           o_tx_start,
    output logic [7:0]     o_tx_byte,
    output logic           o_busy,
    output logic           o_done
);

    localparam int BPW      = LEN / 8;
    localparam int BCW      = cnt_width(BPW);
    localparam int WORD_MAX = (CANT_REG > CANT_MEM) ? CANT_REG : CANT_MEM;
    localparam int WCW      = cnt_width(WORD_MAX);

    localparam logic [BCW-1:0] BYTE_LAST = BCW'(BPW - 1);
    localparam logic [WCW-1:0] REG_LAST  = WCW'(CANT_REG - 1);
    localparam logic [WCW-1:0] MEM_LAST  = WCW'(CANT_MEM - 1);

    state_e         state_q, state_d;
    phase_e         phase_q, phase_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [LEN-1:0] shift_q, shift_d;

    logic           enable_next_q, enable_next_d;
    logic           send_regs_q, send_regs_d;
    logic           tx_start_q, tx_start_d;
    logic [7:0]     tx_byte_q, tx_byte_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;

        case (state_q)
            ST_IDLE: begin
                // The PC is sampled directly, so no collector request precedes it.
                if (i_start) begin
                    state_d = ST_LOAD;
                    phase_d = PH_PC;
                end
            end
            ST_REQ: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d    = (phase_q == PH_PC) ? i_pc : i_data;
                byte_cnt_d = '0;
                state_d    = ST_TX;
            end
            ST_TX: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (byte_cnt_q != BYTE_LAST) begin
                        shift_d    = shift_q >> 8;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = ST_TX;
                    end else begin
                        state_d = ST_REQ;
                        case (phase_q)
                            PH_PC: begin
                                phase_d    = PH_REG;
                                word_cnt_d = '0;
                            end
                            PH_REG: begin
                                if (word_cnt_q == REG_LAST) begin
                                    phase_d    = PH_MEM;
                                    word_cnt_d = '0;
                                end else begin
                                    word_cnt_d = word_cnt_q + 1'b1;
                                end
                            end
                            default: begin
                                if (word_cnt_q == MEM_LAST) begin
                                    state_d = ST_DONE;
                                end else begin
                                    word_cnt_d = word_cnt_q + 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        enable_next_d = (state_d == ST_REQ);
        send_regs_d   = (phase_d == PH_REG);
        tx_start_d    = (state_d == ST_TX);
        tx_byte_d     = tx_start_d ? shift_d[7:0] : 8'h00;
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            phase_q       <= PH_PC;
            byte_cnt_q    <= '0;
            word_cnt_q    <= '0;
            shift_q       <= '0;
            enable_next_q <= 1'b0;
            send_regs_q   <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_byte_q     <= 8'h00;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            byte_cnt_q    <= byte_cnt_d;
            word_cnt_q    <= word_cnt_d;
            shift_q       <= shift_d;
            enable_next_q <= enable_next_d;
            send_regs_q   <= send_regs_d;
            tx_start_q    <= tx_start_d;
            tx_byte_q     <= tx_byte_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign o_enable_next = enable_next_q;
    assign o_send_regs   = send_regs_q;
    assign o_tx_start    = tx_start_q;
    assign o_tx_byte     = tx_byte_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule
